// File: rtl/imem_loader.sv
// Instruction-memory loader: unpacks a length-prefixed byte stream into big-endian 32-bit words
// written at BASE_ADDR, +4, ...; optional trailing XOR checksum when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_e;

    state_e state_q, state_d;

    logic [7:0]        len_hi_q;
    logic [15:0]       len_q;
    logic [15:0]       word_cnt_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       shift_q;
    logic [7:0]        csum_q;

    logic              byte_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              hold_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic              xfer;
    logic              word_done;
    logic              last_byte;
    logic              can_start;
    logic [15:0]       len_rx;

    assign xfer      = byte_valid & byte_ready_q;
    assign word_done = (byte_cnt_q == 2'd3);
    assign last_byte = word_done && (word_cnt_q == (len_q - 16'd1));
    assign can_start = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
    assign len_rx    = {len_hi_q, byte_in};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (32'(len_rx) > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (len_rx == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_FLUSH;
`endif
                end
            end
            S_CHK: begin
                if (xfer) state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
            end
            // One-cycle gap so done never rises in the same cycle as the final write strobe.
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= '0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            csum_q       <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            hold_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK};
            busy_q       <= state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_FLUSH};
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERR);
            hold_q       <= (state_d != S_DONE);
            imem_we_q    <= 1'b0;

            if (can_start) begin
                word_cnt_q <= '0;
                byte_cnt_q <= '0;
                csum_q     <= '0;
            end

            if (xfer) begin
                case (state_q)
                    S_LEN_HI: len_hi_q <= byte_in;
                    S_LEN_LO: len_q    <= len_rx;
                    S_DATA: begin
                        csum_q     <= csum_q ^ byte_in;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        shift_q    <= {shift_q[15:0], byte_in};
                        if (word_done) begin
                            imem_we_q    <= 1'b1;
                            imem_wdata_q <= {shift_q, byte_in};
                            imem_addr_q  <= BASE_ADDR + (ADDR_W'(word_cnt_q) << 2);
                            word_cnt_q   <= word_cnt_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign byte_ready     = byte_ready_q;
    assign imem_we        = imem_we_q;
    assign imem_addr      = imem_addr_q;
    assign imem_wdata     = imem_wdata_q;
    assign cpu_reset_hold = hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frame-level reference model feeding an expected-write
// scoreboard, checked by a per-cycle compare process plus end-of-frame status checks.
module tb_imem_loader;

    localparam int unsigned MAX_WORDS = 256;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset_hold;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(
        .ADDR_W   (32),
        .BASE_ADDR(32'h0),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .cpu_reset_hold(cpu_reset_hold),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned wr_cnt = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] xor_bytes(input bq_t q);
        logic [7:0] x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        return x;
    endfunction

    // Compare process: scoreboard writes, reset values and cross-output rules every cycle.
    initial begin
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        logic        prev_done;
        prev_addr = '0;
        prev_wdata = '0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_addr.delete();
                exp_data.delete();
                check("rst_hold", {31'd0, cpu_reset_hold}, 32'd1);
                check("rst_ready", {31'd0, byte_ready}, 32'd0);
                check("rst_we", {31'd0, imem_we}, 32'd0);
                check("rst_done_err", {30'd0, done, error}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_addr", imem_addr, 32'h0);
                check("rst_wdata", imem_wdata, 32'h0);
                prev_addr = 32'h0;
                prev_wdata = 32'h0;
                prev_done = 1'b0;
            end else begin
                check("hold_vs_done", {31'd0, cpu_reset_hold}, {31'd0, ~done});
                if (byte_ready) check("ready_implies_busy", {31'd0, busy}, 32'd1);
                if (busy) check("busy_excl", {30'd0, done, error}, 32'd0);
                if (error) check("err_no_ready", {31'd0, byte_ready}, 32'd0);
                if (imem_we) begin
                    wr_cnt++;
                    if (exp_addr.size() == 0) begin
                        check("unexpected_we", 32'd1, 32'd0);
                    end else begin
                        check("wr_addr", imem_addr, exp_addr.pop_front());
                        check("wr_data", imem_wdata, exp_data.pop_front());
                    end
                end else begin
                    check("addr_held", imem_addr, prev_addr);
                    check("wdata_held", imem_wdata, prev_wdata);
                end
                if (done && !prev_done) check("done_with_pending", exp_addr.size(), 32'd0);
                prev_addr = imem_addr;
                prev_wdata = imem_wdata;
                prev_done = done;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was transferred.
    task automatic send_byte(input logic [7:0] b, input int unsigned gmin, input int unsigned gmax);
        int unsigned gap;
        gap = $urandom_range(gmax, gmin);
        for (int unsigned i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            byte_in = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_in = b;
        for (int unsigned t = 0; !byte_ready; t++) begin
            if (t >= 20) begin
                check("byte_ready_timeout", 32'd0, 32'd1);
                byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int unsigned n, input bq_t pl,
                             input logic [7:0] chk, input bit exp_err, input bit lit,
                             input int unsigned gmin, input int unsigned gmax, input bit mid_start);
        int unsigned base;
        int unsigned exp_wr;
        bit          accepted;
        logic [15:0] hdr;
        hdr = n[15:0];
        accepted = (n <= MAX_WORDS);
        exp_wr = accepted ? n : 0;
        if (lit) begin
            exp_addr.push_back(32'h0);
            exp_data.push_back(32'h0022_3820);
            exp_addr.push_back(32'h4);
            exp_data.push_back(32'h2022_0030);
        end else if (accepted) begin
            for (int unsigned k = 0; k < n; k++) begin
                exp_addr.push_back(4 * k);
                exp_data.push_back({pl[4*k], pl[4*k+1], pl[4*k+2], pl[4*k+3]});
            end
        end
        base = wr_cnt;
        pulse_start();
        send_byte(hdr[15:8], gmin, gmax);
        start = mid_start;
        send_byte(hdr[7:0], gmin, gmax);
        start = 1'b0;
        if (accepted) begin
            foreach (pl[i]) send_byte(pl[i], gmin, gmax);
`ifdef LOADER_CHECKSUM_EN
            send_byte(chk, gmin, gmax);
`endif
        end
        for (int unsigned t = 0; t < 20 && !(done || error); t++) @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, {31'd0, ~exp_err});
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_hold"}, {31'd0, cpu_reset_hold}, {31'd0, exp_err});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_wr_count"}, wr_cnt - base, exp_wr);
    endtask

    bq_t pl2;
    bq_t empty_q;

    initial begin
        bq_t pl;
        int unsigned n;
        logic [7:0] chk;
        bit err;
        int unsigned base;

        pl2 = '{8'h00, 8'h22, 8'h38, 8'h20, 8'h20, 8'h22, 8'h00, 8'h30};
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_ready", {31'd0, byte_ready}, 32'd0);
        check("idle_hold", {31'd0, cpu_reset_hold}, 32'd1);

        // Checksum 0x08 is the XOR of the eight payload bytes.
        run_frame("t2", 2, pl2, 8'h08, 1'b0, 1'b1, 0, 0, 1'b0);
        run_frame("t3", 2, pl2, 8'h08, 1'b0, 1'b1, 3, 3, 1'b0);
        run_frame("t4", 257, empty_q, 8'h00, 1'b1, 1'b0, 0, 1, 1'b0);
        run_frame("t5a", 0, empty_q, 8'h00, 1'b0, 1'b0, 0, 1, 1'b0);
        run_frame("t5b", 2, pl2, 8'h08, 1'b0, 1'b1, 0, 1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        run_frame("t7", 2, pl2, 8'hFF, 1'b1, 1'b1, 0, 0, 1'b0);
`endif

        // Reset in the middle of the second word: only word 0 was ever written.
        exp_addr.push_back(32'h0);
        exp_data.push_back(32'h0022_3820);
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h02, 0, 0);
        for (int unsigned i = 0; i < 6; i++) send_byte(pl2[i], 0, 1);
        #3 reset = 1'b1;
        @(negedge clk);
        check("t6_ready", {31'd0, byte_ready}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_hold", {31'd0, cpu_reset_hold}, 32'd1);
        check("t6_addr", imem_addr, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("t6_wr_count", wr_cnt - base, 32'd1);
        run_frame("t6_reload", 2, pl2, 8'h08, 1'b0, 1'b1, 0, 1, 1'b0);

        pl.delete();
        for (int unsigned i = 0; i < 4 * MAX_WORDS; i++) pl.push_back(8'($urandom));
        run_frame("max_words", MAX_WORDS, pl, xor_bytes(pl), 1'b0, 1'b0, 0, 0, 1'b0);

        for (int unsigned it = 0; it < 16; it++) begin
            pl.delete();
            if ($urandom_range(7) == 0) n = 257 + $urandom_range(2000);
            else n = $urandom_range(6);
            if (n <= MAX_WORDS) begin
                for (int unsigned i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
            end
            chk = xor_bytes(pl);
            err = (n > MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
            if ($urandom_range(3) == 0) begin
                chk = chk ^ 8'($urandom_range(255, 1));
                err = 1'b1;
            end
`endif
            run_frame("rand", n, pl, chk, err, 1'b0, 0, 2, 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
